// File: rtl/spi_slave_frame.sv
// Full-duplex SPI slave frame engine: parametrised word width and bit order,
// multi-word bursts per chip-select window, TX holding buffer and frame status pulses.
module spi_slave_frame #(
   parameter int DATA_W    = 32,
   parameter bit LSB_FIRST = 1'b0,
   parameter int WCNT_W    = 8
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              cs,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              done,
   output logic              abort,
   output logic              underrun,
   output logic [WCNT_W-1:0] word_cnt,
   output logic              busy
);

   localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

   logic [BC_W-1:0]   bit_cnt;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic [DATA_W-1:0] hold;
   logic              hold_full;
   logic              shift_loaded;
   logic              cs_q;

   logic [DATA_W-1:0] rx_next;
   logic [DATA_W-1:0] tx_next;
   logic [WCNT_W-1:0] wc_base;
   logic              accept;

   assign rx_next  = LSB_FIRST ? {mosi, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], mosi};
   assign tx_next  = LSB_FIRST ? {1'b0, tx_shift[DATA_W-1:1]} : {tx_shift[DATA_W-2:0], 1'b0};
   // A frame start restarts the word count before the first completion is added.
   assign wc_base  = cs_q ? '0 : word_cnt;
   assign accept   = tx_valid && !hold_full;

   assign miso     = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1];
   assign tx_ready = !hold_full;
   assign busy     = !cs_q;

   always_ff @(posedge sclk) begin
      if (!reset) begin
         bit_cnt      <= '0;
         tx_shift     <= '0;
         rx_shift     <= '0;
         rx_data      <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         shift_loaded <= 1'b0;
         rx_valid     <= 1'b0;
         done         <= 1'b0;
         abort        <= 1'b0;
         underrun     <= 1'b0;
         word_cnt     <= '0;
         cs_q         <= 1'b1;
      end else begin
         cs_q     <= cs;
         rx_valid <= 1'b0;
         done     <= 1'b0;
         abort    <= 1'b0;
         underrun <= 1'b0;
         // Accept only when empty, so it never collides with a reload that drains hold.
         if (accept) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end
         if (!cs) begin
            rx_shift <= rx_next;
            underrun <= (bit_cnt == '0) && !shift_loaded;
            if (cs_q)
               word_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
               bit_cnt  <= '0;
               rx_data  <= rx_next;
               rx_valid <= 1'b1;
               word_cnt <= (wc_base == '1) ? wc_base : wc_base + 1'b1;
               if (hold_full) begin
                  tx_shift     <= hold;
                  hold_full    <= 1'b0;
                  shift_loaded <= 1'b1;
               end else begin
                  tx_shift     <= '0;
                  shift_loaded <= 1'b0;
               end
            end else begin
               bit_cnt  <= bit_cnt + 1'b1;
               tx_shift <= tx_next;
            end
         end else if (!cs_q && bit_cnt != '0) begin
            // cs rose mid-word: drop the partial word; any pending hold reloads on a later idle edge.
            abort        <= 1'b1;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            shift_loaded <= 1'b0;
         end else begin
            if (!cs_q && word_cnt != '0)
               done <= 1'b1;
            if (!shift_loaded && hold_full) begin
               tx_shift     <= hold;
               hold_full    <= 1'b0;
               shift_loaded <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_frame.sv
// Self-checking bench for spi_slave_frame: three instances (8b MSB, 8b LSB, 32b MSB)
// share stimulus; each scenario checks the selected instance against a word-level model.
module tb_spi_slave_frame;

   logic        sclk = 1'b0;
   logic        reset = 1'b0;
   logic        cs = 1'b1;
   logic        mosi = 1'b0;
   logic        tx_valid = 1'b0;
   logic [31:0] tx_data = '0;

   always #5 sclk = ~sclk;

   logic       miso_v[3], rdy_v[3], rv_v[3], dn_v[3], ab_v[3], ur_v[3], busy_v[3];
   logic [2:0] wc_v[3];
   logic [7:0] rxd0, rxd1;
   logic [31:0] rxd2;

   spi_slave_frame #(.DATA_W(8), .LSB_FIRST(1'b0), .WCNT_W(3)) u_msb8 (
      .sclk(sclk), .reset(reset), .cs(cs), .mosi(mosi), .miso(miso_v[0]),
      .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(rdy_v[0]),
      .rx_data(rxd0), .rx_valid(rv_v[0]), .done(dn_v[0]), .abort(ab_v[0]),
      .underrun(ur_v[0]), .word_cnt(wc_v[0]), .busy(busy_v[0]));

   spi_slave_frame #(.DATA_W(8), .LSB_FIRST(1'b1), .WCNT_W(3)) u_lsb8 (
      .sclk(sclk), .reset(reset), .cs(cs), .mosi(mosi), .miso(miso_v[1]),
      .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(rdy_v[1]),
      .rx_data(rxd1), .rx_valid(rv_v[1]), .done(dn_v[1]), .abort(ab_v[1]),
      .underrun(ur_v[1]), .word_cnt(wc_v[1]), .busy(busy_v[1]));

   spi_slave_frame #(.DATA_W(32), .LSB_FIRST(1'b0), .WCNT_W(3)) u_msb32 (
      .sclk(sclk), .reset(reset), .cs(cs), .mosi(mosi), .miso(miso_v[2]),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_v[2]),
      .rx_data(rxd2), .rx_valid(rv_v[2]), .done(dn_v[2]), .abort(ab_v[2]),
      .underrun(ur_v[2]), .word_cnt(wc_v[2]), .busy(busy_v[2]));

   int          sel = 0;
   logic        miso_s, rdy_s, rv_s, dn_s, ab_s, ur_s, busy_s;
   logic [2:0]  wc_s;
   logic [31:0] rxd_s;

   always_comb begin
      miso_s = miso_v[sel];
      rdy_s  = rdy_v[sel];
      rv_s   = rv_v[sel];
      dn_s   = dn_v[sel];
      ab_s   = ab_v[sel];
      ur_s   = ur_v[sel];
      busy_s = busy_v[sel];
      wc_s   = wc_v[sel];
      rxd_s  = rxd2;
      if (sel == 0) rxd_s = {24'd0, rxd0};
      else if (sel == 1) rxd_s = {24'd0, rxd1};
   end

   int          total = 0;
   int          bad = 0;
   logic        miso_pre;
   logic [31:0] txq[$];
   logic [31:0] tw[16];
   logic [31:0] rw[16];

   function automatic int width();
      return (sel == 2) ? 32 : 8;
   endfunction

   function automatic logic [31:0] wmask();
      return (sel == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction

   // One sclk cycle: drive at the falling edge, let the rising edge act, return at the next falling edge.
   task automatic tick(input logic c, input logic m);
      logic [31:0] junk;
      cs   = c;
      mosi = m;
      if (txq.size() > 0 && rdy_s && reset) begin
         tx_valid = 1'b1;
         tx_data  = txq[0];
      end else begin
         tx_valid = 1'b0;
         tx_data  = $urandom;
      end
      miso_pre = miso_s;
      @(posedge sclk);
      if (tx_valid) junk = txq.pop_front();
      @(negedge sclk);
      tx_valid = 1'b0;
   endtask

   task automatic do_reset();
      txq.delete();
      reset = 1'b0;
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      reset = 1'b1;
   endtask

   // n words per frame, first s of tw[] offered greedily; words past s must underrun and send zeros.
   task automatic run_burst(input int n, input int s);
      int          w;
      int          bi;
      bit          lsb;
      logic [31:0] cap;
      logic [31:0] exp_tx;
      int          ewc;
      w   = width();
      lsb = (sel == 1);
      txq.delete();
      for (int i = 0; i < s; i++) txq.push_back(tw[i] & wmask());
      repeat (4) tick(1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         exp_tx = (i < s) ? (tw[i] & wmask()) : 32'd0;
         cap = '0;
         for (int b = 0; b < w; b++) begin
            bi = lsb ? b : w - 1 - b;
            tick(1'b0, rw[i][bi]);
            cap[bi] = miso_pre;
            total++;
            if (rv_s !== (b == w - 1) || ur_s !== (b == 0 && i >= s) || dn_s !== 1'b0 ||
                ab_s !== 1'b0 || busy_s !== 1'b1) begin
               bad++;
               $display("FAIL pulses sel=%0d word=%0d bit=%0d: rx_valid=%b underrun=%b done=%b abort=%b busy=%b (want rv=%b ur=%b dn=0 ab=0 busy=1)",
                        sel, i, b, rv_s, ur_s, dn_s, ab_s, busy_s, (b == w - 1), (b == 0 && i >= s));
            end
            if (i == 0 && b == 0) begin
               total++;
               if (wc_s !== 3'd0) begin
                  bad++;
                  $display("FAIL frame_start_wcnt sel=%0d: got %0d want 0", sel, wc_s);
               end
            end
         end
         ewc = (i + 1 > 7) ? 7 : i + 1;
         total++;
         if (cap !== exp_tx) begin
            bad++;
            $display("FAIL miso_word sel=%0d word=%0d: got %h want %h", sel, i, cap, exp_tx);
         end
         total++;
         if (rxd_s !== (rw[i] & wmask())) begin
            bad++;
            $display("FAIL rx_data sel=%0d word=%0d: got %h want %h", sel, i, rxd_s, rw[i] & wmask());
         end
         total++;
         if (wc_s !== 3'(ewc)) begin
            bad++;
            $display("FAIL word_cnt sel=%0d word=%0d: got %0d want %0d", sel, i, wc_s, ewc);
         end
      end
      ewc = (n > 7) ? 7 : n;
      tick(1'b1, 1'b0);
      total++;
      if (dn_s !== 1'b1 || ab_s !== 1'b0 || rv_s !== 1'b0 || busy_s !== 1'b0 || wc_s !== 3'(ewc)) begin
         bad++;
         $display("FAIL frame_end sel=%0d: done=%b abort=%b rv=%b busy=%b wc=%0d want done=1 abort=0 rv=0 busy=0 wc=%0d",
                  sel, dn_s, ab_s, rv_s, busy_s, wc_s, ewc);
      end
      tick(1'b1, 1'b0);
      total++;
      if (dn_s !== 1'b0) begin
         bad++;
         $display("FAIL done_width sel=%0d: got %b want 0", sel, dn_s);
      end
   endtask

   task automatic test_reset();
      sel = 2;
      do_reset();
      total++;
      if (miso_s !== 1'b0 || rdy_s !== 1'b1 || wc_s !== 3'd0 || busy_s !== 1'b0 || rxd_s !== 32'd0 ||
          rv_s !== 1'b0 || dn_s !== 1'b0 || ab_s !== 1'b0 || ur_s !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: miso=%b rdy=%b wc=%0d busy=%b rxd=%h rv=%b dn=%b ab=%b ur=%b",
                  miso_s, rdy_s, wc_s, busy_s, rxd_s, rv_s, dn_s, ab_s, ur_s);
      end
   endtask

   task automatic test_msb8();
      sel = 0;
      do_reset();
      tw[0] = 32'hA5;
      rw[0] = 32'h3C;
      run_burst(1, 1);
   endtask

   task automatic test_lsb8();
      sel = 1;
      do_reset();
      tw[0] = 32'h01;
      rw[0] = 32'h01;
      run_burst(1, 1);
   endtask

   task automatic test_burst32();
      sel = 2;
      do_reset();
      tw[0] = 32'hDEADBEEF; tw[1] = 32'h12345678; tw[2] = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) rw[i] = $urandom;
      run_burst(3, 3);
   endtask

   task automatic test_underrun();
      sel = 2;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         tw[i] = $urandom;
         rw[i] = $urandom;
      end
      run_burst(2, 1);
   endtask

   task automatic test_abort();
      sel = 0;
      do_reset();
      tw[0] = $urandom;
      txq.delete();
      txq.push_back(tw[0] & 32'hFF);
      repeat (4) tick(1'b1, 1'b0);
      repeat (5) tick(1'b0, 1'($urandom));
      tick(1'b1, 1'b0);
      total++;
      if (ab_s !== 1'b1 || dn_s !== 1'b0 || rv_s !== 1'b0 || wc_s !== 3'd0) begin
         bad++;
         $display("FAIL abort_pulse: abort=%b done=%b rv=%b wc=%0d want abort=1 done=0 rv=0 wc=0", ab_s, dn_s, rv_s, wc_s);
      end
      tick(1'b1, 1'b0);
      total++;
      if (ab_s !== 1'b0 || dn_s !== 1'b0) begin
         bad++;
         $display("FAIL abort_width: abort=%b done=%b want 0 0", ab_s, dn_s);
      end
      for (int i = 0; i < 2; i++) begin
         tw[i] = $urandom;
         rw[i] = $urandom;
      end
      run_burst(2, 2);
   endtask

   task automatic test_reset_mid_word();
      sel = 2;
      do_reset();
      tw[0] = $urandom; tw[1] = $urandom;
      txq.delete();
      txq.push_back(tw[0]);
      txq.push_back(tw[1]);
      repeat (4) tick(1'b1, 1'b0);
      total++;
      if (rdy_s !== 1'b0) begin
         bad++;
         $display("FAIL hold_preload: tx_ready=%b want 0", rdy_s);
      end
      repeat (3) tick(1'b0, 1'($urandom));
      reset = 1'b0;
      tick(1'b0, 1'b1);
      total++;
      if (miso_s !== 1'b0 || rdy_s !== 1'b1 || wc_s !== 3'd0 || rv_s !== 1'b0 || dn_s !== 1'b0 ||
          ab_s !== 1'b0 || ur_s !== 1'b0 || busy_s !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_word: miso=%b rdy=%b wc=%0d rv=%b dn=%b ab=%b ur=%b busy=%b",
                  miso_s, rdy_s, wc_s, rv_s, dn_s, ab_s, ur_s, busy_s);
      end
      reset = 1'b1;
      txq.delete();
      tick(1'b1, 1'b0);
      total++;
      if (dn_s !== 1'b0 || ab_s !== 1'b0 || rv_s !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_pulse: done=%b abort=%b rv=%b want 0", dn_s, ab_s, rv_s);
      end
      for (int i = 0; i < 2; i++) begin
         tw[i] = $urandom;
         rw[i] = $urandom;
      end
      run_burst(2, 2);
   endtask

   task automatic test_back_to_back();
      sel = 2;
      do_reset();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 2; i++) begin
            tw[i] = $urandom;
            rw[i] = $urandom;
         end
         run_burst(2, 2);
      end
   endtask

   task automatic test_saturate();
      sel = 0;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         tw[i] = $urandom;
         rw[i] = $urandom;
      end
      run_burst(9, 9);
   endtask

   task automatic test_random();
      int n;
      int s;
      for (int it = 0; it < 8; it++) begin
         sel = $urandom_range(0, 2);
         do_reset();
         n = $urandom_range(1, 4);
         s = $urandom_range(0, n);
         for (int i = 0; i < n; i++) begin
            tw[i] = $urandom;
            rw[i] = $urandom;
         end
         run_burst(n, s);
      end
   endtask

   initial begin
      @(negedge sclk);
      test_reset();
      test_msb8();
      test_lsb8();
      test_burst32();
      test_underrun();
      test_abort();
      test_reset_mid_word();
      test_back_to_back();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
